cpu_mem_arbiter: RTL and testbench

//  Shares one downstream memory port between the multi-cycle CPU's instruction-fetch channel and its data channel.

---
 rtl/cpu_mem_arb_pkg.sv | 15 +
 rtl/cpu_mem_arbiter_if.sv | 28 ++
 rtl/cpu_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared encodings for the CPU memory arbiter: FSM states and response owner IDs.
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Downstream memory port of the arbiter. Request: mem_req_valid held until mem_req_ready,
// transfer on valid&ready, fields stable while valid. Response: transfer on mem_rvalid&mem_rready.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_rready;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, mem_rready,
    input  mem_req_ready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, mem_rready,
    output mem_req_ready, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch and load/store channels: one request at a time,
// data wins ties, stores are posted, read data is routed back to the channel that asked for it.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                Inst_Req_Valid,
  input  logic [ADDR_W-1:0]   PC,
  output logic                Inst_Req_Ready,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ready,

  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  output logic                Mem_Req_Ready,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ready,

  cpu_mem_arbiter_if.master   mem,

  output logic [31:0]         perf_inst_grants,
  output logic [31:0]         perf_data_grants,
  output logic [31:0]         perf_wait_cycles,
  output arb_state_t          dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state;
  arb_owner_t          owner;
  logic                req_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic data_req;
  logic in_idle;
  logic in_resp;
  logic grant_data;
  logic grant_inst;
  logic rready;
  logic wait_cycle;

  // Grants are gated by rst so that no ready pulse escapes while reset is asserted.
  assign data_req   = MemRead | MemWrite;
  assign in_idle    = (state == ST_IDLE) && rst;
  assign in_resp    = (state == ST_RESP);
  assign grant_data = in_idle & data_req;
  assign grant_inst = in_idle & ~data_req & Inst_Req_Valid;
  assign rready     = in_resp & ((owner == OWN_DATA) ? Read_data_Ready : Inst_Ready);
  assign wait_cycle = (Inst_Req_Valid & ~grant_inst) | (data_req & ~grant_data);

  assign Inst_Req_Ready  = grant_inst;
  assign Mem_Req_Ready   = grant_data;
  assign Instruction     = mem.mem_rdata;
  assign Read_data       = mem.mem_rdata;
  assign Inst_Valid      = in_resp & (owner == OWN_INST) & mem.mem_rvalid;
  assign Read_data_Valid = in_resp & (owner == OWN_DATA) & mem.mem_rvalid;

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wstrb     = wstrb_q;
  assign mem.mem_rready    = rready;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_INST;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_data || grant_inst) begin
            state       <= ST_REQ;
            req_valid_q <= 1'b1;
            owner       <= grant_data ? OWN_DATA : OWN_INST;
            addr_q      <= grant_data ? Address : PC;
            // A simultaneous MemRead/MemWrite is treated as a store.
            we_q        <= grant_data & MemWrite;
            wdata_q     <= grant_data ? Write_data : '0;
            wstrb_q     <= (grant_data && MemWrite) ? Write_strb : '0;
          end
        end
        ST_REQ: begin
          if (mem.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= we_q ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem.mem_rvalid && rready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_inst_grants <= '0;
      perf_data_grants <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (grant_inst) perf_inst_grants <= perf_inst_grants + 32'd1;
      if (grant_data) perf_data_grants <= perf_data_grants + 32'd1;
      if (wait_cycle) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model with a memory image and an expected-read-data queue.
module tb_cpu_mem_arbiter;
  import cpu_mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        Inst_Req_Valid;
  logic [31:0] PC;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] perf_inst_grants;
  logic [31:0] perf_data_grants;
  logic [31:0] perf_wait_cycles;
  arb_state_t  dbg_state;

  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .Inst_Req_Valid(Inst_Req_Valid), .PC(PC), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .mem(mem_bus.master),
    .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_wait_cycles(perf_wait_cycles), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  logic        m_busy;
  logic        m_issued;
  txn_t        m_txn;
  logic [31:0] m_ig, m_dg, m_wc;
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] exp_q [$];

  // memory responder state
  logic [31:0] rmem [logic [31:0]];
  logic        rd_pending;
  logic [31:0] rd_addr;
  logic        hs_wr, hs_rd, hs_resp;
  logic [31:0] hs_addr, hs_wdata;
  logic [3:0]  hs_strb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mmem_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare + model (one call per cycle, at negedge) ----------------
  task automatic at_neg();
    logic dreq, e_irr, e_mrr, e_mrv, e_rr, e_iv, e_dv;
    txn_t t;
    @(negedge clk);
    dreq  = MemRead | MemWrite;
    e_irr = 1'b0; e_mrr = 1'b0; e_mrv = 1'b0; e_rr = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
    hs_wr = 1'b0; hs_rd = 1'b0; hs_resp = 1'b0;
    if (rst) begin
      if (!m_busy) begin
        e_mrr = dreq;
        e_irr = !dreq && Inst_Req_Valid;
      end else if (!m_issued) begin
        e_mrv = 1'b1;
      end else begin
        e_rr = m_txn.is_data ? Read_data_Ready : Inst_Ready;
        e_iv = !m_txn.is_data && mem_bus.mem_rvalid;
        e_dv = m_txn.is_data && mem_bus.mem_rvalid;
      end
    end
    chk("inst_req_ready", 32'(Inst_Req_Ready), 32'(e_irr));
    chk("mem_req_ready_up", 32'(Mem_Req_Ready), 32'(e_mrr));
    chk("mem_req_valid", 32'(mem_bus.mem_req_valid), 32'(e_mrv));
    chk("mem_rready", 32'(mem_bus.mem_rready), 32'(e_rr));
    chk("inst_valid", 32'(Inst_Valid), 32'(e_iv));
    chk("read_data_valid", 32'(Read_data_Valid), 32'(e_dv));
    chk("perf_inst_grants", perf_inst_grants, rst ? m_ig : 32'h0);
    chk("perf_data_grants", perf_data_grants, rst ? m_dg : 32'h0);
    chk("perf_wait_cycles", perf_wait_cycles, rst ? m_wc : 32'h0);
    if (e_mrv) begin
      chk("mem_addr", mem_bus.mem_addr, m_txn.addr);
      chk("mem_we", 32'(mem_bus.mem_we), 32'(m_txn.we));
      chk("mem_wstrb", 32'(mem_bus.mem_wstrb), m_txn.we ? 32'(m_txn.strb) : 32'h0);
      if (m_txn.we) chk("mem_wdata", mem_bus.mem_wdata, m_txn.wdata);
    end
    if (e_iv || e_dv) begin
      if (exp_q.size() == 0) chk("resp_without_expected", 32'h1, 32'h0);
      else if (e_iv) chk("instruction", Instruction, exp_q[0]);
      else chk("read_data", Read_data, exp_q[0]);
    end

    // responder bookkeeping from what the bus actually shows
    if (rst) begin
      hs_addr  = mem_bus.mem_addr;
      hs_wdata = mem_bus.mem_wdata;
      hs_strb  = mem_bus.mem_wstrb;
      hs_wr    = mem_bus.mem_req_valid && mem_bus.mem_req_ready && mem_bus.mem_we;
      hs_rd    = mem_bus.mem_req_valid && mem_bus.mem_req_ready && !mem_bus.mem_we;
      hs_resp  = mem_bus.mem_rvalid && mem_bus.mem_rready;
    end

    // model advance to the next clock edge
    if (!rst) begin
      m_busy = 1'b0; m_issued = 1'b0;
      m_ig = 0; m_dg = 0; m_wc = 0;
      exp_q.delete();
    end else begin
      if ((Inst_Req_Valid && !e_irr) || (dreq && !e_mrr)) m_wc = m_wc + 1;
      if (e_irr || e_mrr) begin
        t.is_data = e_mrr;
        t.we      = e_mrr && MemWrite;
        t.addr    = e_mrr ? Address : PC;
        t.wdata   = Write_data;
        t.strb    = Write_strb;
        if (e_mrr) m_dg = m_dg + 1; else m_ig = m_ig + 1;
        if (t.we) mmem[t.addr] = merge(mmem_rd(t.addr), t.wdata, t.strb);
        else exp_q.push_back(mmem_rd(t.addr));
        m_txn = t; m_busy = 1'b1; m_issued = 1'b0;
      end else if (m_busy && !m_issued) begin
        if (mem_bus.mem_req_ready) begin
          if (m_txn.we) m_busy = 1'b0; else m_issued = 1'b1;
        end
      end else if (m_busy && m_issued && mem_bus.mem_rvalid && e_rr) begin
        m_busy = 1'b0;
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    if (!rst) rd_pending = 1'b0;
    else begin
      if (hs_wr) rmem[hs_addr] = merge(rmem_rd(hs_addr), hs_wdata, hs_strb);
      if (hs_rd) begin rd_pending = 1'b1; rd_addr = hs_addr; end
      else if (hs_resp) rd_pending = 1'b0;
    end
    #1;
    mem_bus.mem_rdata = rd_pending ? rmem_rd(rd_addr) : $urandom;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input logic [31:0] pc_v, input logic mr, input logic mw,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic mrdy, input logic mrv);
    Inst_Req_Valid = iv; PC = pc_v;
    MemRead = mr; MemWrite = mw; Address = a; Write_data = wd; Write_strb = st;
    mem_bus.mem_req_ready = mrdy; mem_bus.mem_rvalid = mrv;
  endtask

  initial begin
    rst = 1'b0;
    m_busy = 1'b0; m_issued = 1'b0; m_ig = 0; m_dg = 0; m_wc = 0;
    rd_pending = 1'b0; rd_addr = 0;
    hs_wr = 1'b0; hs_rd = 1'b0; hs_resp = 1'b0; hs_addr = 0; hs_wdata = 0; hs_strb = 0;
    m_txn = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    Inst_Ready = 1'b1; Read_data_Ready = 1'b1;
    mem_bus.mem_rdata = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mmem[32'h1000] = 32'hDEADBEEF;
    rmem[32'h1000] = 32'hDEADBEEF;
    repeat (3) cyc();
    rst = 1'b1;
    at_neg();
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_inst_grants", perf_inst_grants, 32'h0);
    to_pos();

    // 1: single fetch
    drive(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t1_grant", 32'(Inst_Req_Ready), 32'h1); to_pos();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    at_neg();
    chk("t1_inst_valid", 32'(Inst_Valid), 32'h1);
    chk("t1_instruction", Instruction, 32'hDEADBEEF);
    chk("t1_rd_valid_low", 32'(Read_data_Valid), 32'h0);
    to_pos();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t1_inst_grants", perf_inst_grants, 32'h1); to_pos();

    // 2: simultaneous fetch and load, data first
    drive(1, 32'h2000, 1, 0, 32'h1000, 0, 0, 0, 0);
    at_neg();
    chk("t2_data_first", 32'(Mem_Req_Ready), 32'h1);
    chk("t2_fetch_waits", 32'(Inst_Req_Ready), 32'h0);
    to_pos();
    drive(1, 32'h2000, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(1, 32'h2000, 0, 0, 0, 0, 0, 0, 1);
    at_neg(); chk("t2_load_data", Read_data, 32'hDEADBEEF); to_pos();
    drive(1, 32'h2000, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t2_fetch_granted", 32'(Inst_Req_Ready), 32'h1);
    chk("t2_wait_cycles", perf_wait_cycles, 32'd3);
    chk("t2_data_grants", perf_data_grants, 32'd1);
    to_pos();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();

    // 3: posted store
    drive(0, 0, 0, 1, 32'h20, 32'h11223344, 4'b0100, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    at_neg();
    chk("t3_we", 32'(mem_bus.mem_we), 32'h1);
    chk("t3_wstrb", 32'(mem_bus.mem_wstrb), 32'h4);
    chk("t3_addr", mem_bus.mem_addr, 32'h20);
    chk("t3_wdata", mem_bus.mem_wdata, 32'h11223344);
    to_pos();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t3_back_idle", 32'(dbg_state), 32'(ST_IDLE)); to_pos();

    // 4: downstream stall with requests still pending upstream
    drive(1, 32'h40, 1, 0, 32'h20, 0, 0, 0, 0); cyc();
    drive(1, 32'h40, 1, 0, 32'h80, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t4_req_valid_held", 32'(mem_bus.mem_req_valid), 32'h1);
      chk("t4_addr_stable", mem_bus.mem_addr, 32'h20);
      chk("t4_no_up_ready", 32'(Inst_Req_Ready | Mem_Req_Ready), 32'h0);
      to_pos();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();

    // 5: owner not ready in RESP
    Read_data_Ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t5_rready_low", 32'(mem_bus.mem_rready), 32'h0);
      chk("t5_stay_resp", 32'(dbg_state), 32'(ST_RESP));
      chk("t5_merged_data", Read_data, 32'h0022_0000);
      to_pos();
    end
    Read_data_Ready = 1'b1;
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t5_idle_after", 32'(dbg_state), 32'(ST_IDLE)); to_pos();

    // 6: asynchronous reset in REQ
    drive(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_req_valid_cleared", 32'(mem_bus.mem_req_valid), 32'h0);
    chk("t6_no_ready_in_reset", 32'(Inst_Req_Ready), 32'h0);
    chk("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_counter_cleared", perf_inst_grants, 32'h0);
    cyc();
    rst = 1'b1;
    drive(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t6_regrant", 32'(Inst_Req_Ready), 32'h1); to_pos();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    at_neg(); chk("t6_fetch_data", Instruction, 32'hDEADBEEF); to_pos();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 2) != 0), 32'($urandom_range(0, 15)) << 2,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      Inst_Ready      = ($urandom_range(0, 3) != 0);
      Read_data_Ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
